// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding core-side initiator for a byte-addressed,
// little-endian, word-wide data memory. Sub-word stores are merged by
// read-modify-write; loads are extracted and sign/zero-extended.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_memData
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRead, StWrite, StResp} state_t;

  state_t      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        err_illegal;
  logic        err_misaligned;
  logic        err_range;
  logic [1:0]  err_code;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Request error classification, highest priority first.
  always_comb begin
    err_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_funct3[2] && req_write);
    err_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    err_range      = req_addr >= 32'(MEM_BYTES);
    if (err_illegal)         err_code = 2'b11;
    else if (err_misaligned) err_code = 2'b01;
    else if (err_range)      err_code = 2'b10;
    else                     err_code = 2'b00;
  end

  // Lane extraction and extension of the returned memory word.
  always_comb begin
    sel_byte = mem_memData[{lane_q, 3'b000} +: 8];
    sel_half = lane_q[1] ? mem_memData[31:16] : mem_memData[15:0];
    unique case (funct3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = mem_memData;
    endcase
  end

  // Sub-word store merge into the word just read.
  always_comb begin
    merged_word = mem_memData;
    if (funct3_q[1:0] == 2'b00) begin
      merged_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Handshake and strobe decode; strobes are forced low while reset is high.
  assign req_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign mem_memRead  = !reset && ((state_q == StLoad) || (state_q == StRmwRead));
  assign mem_memWrite = !reset && (state_q == StWrite);

  // Control FSM with registered response and memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      funct3_q      <= 3'b000;
      lane_q        <= 2'b00;
      wdata_q       <= 32'h0;
      rsp_rdata     <= 32'h0;
      rsp_err       <= 2'b00;
      mem_address   <= 32'h0;
      mem_writeData <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            funct3_q  <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            rsp_rdata <= 32'h0;
            rsp_err   <= err_code;
            if (err_code != 2'b00) begin
              // Errored requests never touch memory; mem_address keeps its value.
              state_q <= StResp;
            end else begin
              mem_address <= {req_addr[31:2], 2'b00};
              if (!req_write) begin
                state_q <= StLoad;
              end else if (req_funct3[1:0] == 2'b10) begin
                mem_writeData <= req_wdata;
                state_q       <= StWrite;
              end else begin
                state_q <= StRmwRead;
              end
            end
          end
        end
        StLoad: begin
          rsp_rdata <= load_data;
          state_q   <= StResp;
        end
        StRmwRead: begin
          mem_writeData <= merged_word;
          state_q       <= StWrite;
        end
        StWrite: begin
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_memData;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  logic [7:0] mem [256];
  logic [7:0] wa;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_memRead   (mem_memRead),
    .mem_memWrite  (mem_memWrite),
    .mem_memData   (mem_memData)
  );

  // Combinational read port of the memory model.
  always_comb begin
    wa = {mem_address[7:2], 2'b00};
    mem_memData = {mem[wa + 8'd3], mem[wa + 8'd2], mem[wa + 8'd1], mem[wa]};
  end

  // Word write at the edge ending a write-strobe cycle.
  always @(posedge clk) begin
    if (mem_memWrite) begin
      mem[wa]        <= mem_writeData[7:0];
      mem[wa + 8'd1] <= mem_writeData[15:8];
      mem[wa + 8'd2] <= mem_writeData[23:16];
      mem[wa + 8'd3] <= mem_writeData[31:24];
      wr_pulses++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; hold = number of RESP cycles with rsp_ready low before the handshake.
  task automatic xact(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rdata,
                      input logic [1:0] exp_err, input int exp_rd, input int exp_wr,
                      input logic [31:0] exp_wd, input int hold);
    int lat, nrd, nwr;
    logic [31:0] wd_seen;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = (hold == 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    lat = 1; nrd = 0; nwr = 0; wd_seen = 32'h0;
    while (!rsp_valid && lat < 10) begin
      chk({tag, "_strobe_excl"}, 32'(mem_memRead && mem_memWrite), 32'd0);
      if (mem_memRead) nrd++;
      if (mem_memWrite) begin nwr++; wd_seen = mem_writeData; end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_nread"}, 32'(nrd), 32'(exp_rd));
    chk({tag, "_nwrite"}, 32'(nwr), 32'(exp_wr));
    if (exp_wr > 0) chk({tag, "_wdata"}, wd_seen, exp_wd);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_hold_strobes"}, 32'({mem_memRead, mem_memWrite}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'h0);
    chk({tag, "_mem_writeData"}, mem_writeData, 32'h0);
    chk({tag, "_strobes"}, 32'({mem_memRead, mem_memWrite}), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int wr_before;
    bit saw_valid;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_outputs("reset");

    // Word store/load round trip.
    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 2'b00, 0, 1, 32'hDEADBEEF, 0);
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 2'b00, 1, 0, 32'h0, 0);
    // Backpressure: rsp_ready low for 3 RESP cycles.
    xact("lw_bp", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 2'b00, 1, 0, 32'h0, 3);
    xact("lw_after_bp", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 2'b00, 1, 0, 32'h0, 0);

    // Byte store via RMW and byte loads.
    xact("sb11", 1'b1, 3'b000, 32'h11, 32'hFFFF_FF5A, 3, 32'h0, 2'b00, 1, 1, 32'hDEAD5AEF, 0);
    xact("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 2, 32'hFFFFFFDE, 2'b00, 1, 0, 32'h0, 0);
    xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h000000DE, 2'b00, 1, 0, 32'h0, 0);

    // Half store via RMW and half/byte loads.
    xact("sh12", 1'b1, 3'b001, 32'h12, 32'h1234_8001, 3, 32'h0, 2'b00, 1, 1, 32'h80015AEF, 0);
    xact("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFF8001, 2'b00, 1, 0, 32'h0, 0);
    xact("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 2, 32'h00008001, 2'b00, 1, 0, 32'h0, 0);
    xact("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 2, 32'h0000005A, 2'b00, 1, 0, 32'h0, 0);
    xact("lh10", 1'b0, 3'b001, 32'h10, 32'h0, 2, 32'h00005AEF, 2'b00, 1, 0, 32'h0, 0);

    // Error responses: latency 1, no strobes, rdata 0.
    xact("err_mis", 1'b0, 3'b010, 32'h0E, 32'h0, 1, 32'h0, 2'b01, 0, 0, 32'h0, 0);
    xact("err_mis_h", 1'b1, 3'b001, 32'h13, 32'h0, 1, 32'h0, 2'b01, 0, 0, 32'h0, 0);
    xact("err_oor", 1'b1, 3'b010, 32'h100, 32'h1, 1, 32'h0, 2'b10, 0, 0, 32'h0, 0);
    xact("err_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 2'b11, 0, 0, 32'h0, 0);
    xact("err_st_100", 1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 2'b11, 0, 0, 32'h0, 0);
    // Illegal beats misaligned beats out of range.
    xact("err_prio", 1'b1, 3'b101, 32'h101, 32'h0, 1, 32'h0, 2'b11, 0, 0, 32'h0, 0);
    xact("err_prio2", 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 2'b01, 0, 0, 32'h0, 0);
    xact("lw_intact", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h80015AEF, 2'b00, 1, 0, 32'h0, 0);

    // Reset during RMW_READ of an SB: no write, no response.
    wr_before = wr_pulses;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h20; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_in_rmw_read", 32'(mem_memRead), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_gates_read", 32'(mem_memRead), 32'd0);
    saw_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_valid = 1'b1;
    end
    reset = 1'b0;
    chk_reset_outputs("rst_mid");
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("rst_no_rsp", 32'(saw_valid), 32'd0);
    chk("rst_no_write", 32'(wr_pulses - wr_before), 32'd0);
    chk("rst_mem20", {mem[35], mem[34], mem[33], mem[32]}, 32'h0);
    xact("lw_post_rst", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h80015AEF, 2'b00, 1, 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the byte-addressed, little-endian data memory in the multicycle RISC-V design. It accepts one load or store request at a time from the control path. It converts LB/LH/LW/LBU/LHU/SB/SH/SW into memRead/memWrite strobes, merging sub-word stores by read-modify-write. It returns sign- or zero-extended load data or an error code through a valid/ready response.

## Interface
- MEM_BYTES, default 256: memory size in bytes; a power of two and a multiple of 4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on the edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (100/101 loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; only low 8/16 bits used for byte/half.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed on the edge where rsp_valid && rsp_ready.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- mem_address  out  32  word-aligned address to memory (addr & ~3).
- mem_writeData  out  32  full word to write.
- mem_memRead  out  1  read strobe; memory returns mem_memData combinationally.
- mem_memWrite  out  1  write strobe; memory commits 4 bytes at the edge ending the cycle.
- mem_memData  in  32  read data.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: on acceptance, latch write, funct3, addr, wdata and lane = addr[1:0], then check errors in priority order:
  - illegal funct3: 011/110/111, or 100/101 with req_write=1 → err 11;
  - misaligned: half with addr[0]=1, or word with addr[1:0]≠0 → err 01;
  - out of range: addr ≥ MEM_BYTES → err 10.
- IDLE transitions: any error → RESP, with no memory strobe ever asserted. Otherwise load → LOAD; SW → WRITE; SB/SH → RMW_READ.
- LOAD: mem_memRead=1 for this cycle. Select the byte at lane, or the half at lane[1]*16, from mem_memData. Sign-extend (000/001) or zero-extend (100/101); word passes through. Register into rsp_rdata → RESP.
- RMW_READ: mem_memRead=1. Register the merged word: mem_memData with the byte (lane) or half (lane[1]) replaced by wdata[7:0] / wdata[15:0] → WRITE.
- WRITE: mem_memWrite=1. mem_writeData = merged word (SB/SH) or wdata (SW) → RESP.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err stable. → IDLE on rsp_ready; otherwise hold.
- mem_memRead and mem_memWrite are decoded from state and are never high together. Both are gated low while reset=1.
- mem_address is valid whenever a strobe is high and otherwise holds its last value. All accesses are word-aligned, so no access crosses MEM_BYTES.

## Timing
- Reset: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=00, mem_address=0, mem_writeData=0, both strobes 0. req_ready=1 from the first cycle after reset deasserts.
- Latency, counted from the accept edge to the first cycle with rsp_valid=1:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- Throughput: the next request can be accepted in the cycle after the response handshake; there is no overlap.
- Backpressure: while rsp_ready=0 in RESP, all outputs hold, req_ready=0, and no strobes are asserted.
- Reset mid-operation wins: the next state is IDLE and any pending response is dropped. A write in WRITE during the reset cycle is suppressed (strobe gated).
- req_* inputs are don't-care except in IDLE; changes outside IDLE have no effect.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → one mem_memWrite pulse with writeData 0xDEADBEEF; rsp_rdata 0xDEADBEEF, err 00; both latencies 2.
- SB 0x5A @0x11 → one memRead cycle then one memWrite cycle of 0xDEAD5AEF, latency 3. Then LB @0x13 → 0xFFFFFFDE and LBU @0x13 → 0x000000DE.
- SH 0x8001 @0x12 → word 0x80015AEF. Then LH @0x12 → 0xFFFF8001, LHU @0x12 → 0x00008001, LB @0x11 → 0x0000005A.
- Errors, each at latency 1 with no strobes and rsp_rdata 0:
  - LW @0x0E → err 01;
  - SW @0x100 (MEM_BYTES=256) → err 10;
  - funct3 011 → err 11;
  - store with funct3 100 → err 11.
- Backpressure: LW with rsp_ready low for 3 cycles → rsp_valid and 0xDEADBEEF held 4 cycles; req_ready stays 0 and no strobes fire; the next request is accepted the cycle after the handshake.
- Reset asserted during RMW_READ of an SB → no mem_memWrite pulse, rsp_valid never asserted; all outputs return to reset values and req_ready=1 after reset.
